// File: rtl/collision_scorer.sv
// Collision and score keeper for the flappy-bird game: detects pipe/floor/ceiling
// hits, drives Lost back to the pipe generator, and counts cleared pipes in BCD.
module collision_scorer #(
    parameter logic [10:0] BIRD_X   = 11'd200,
    parameter logic [10:0] BIRD_SZ  = 11'd20,
    parameter logic [10:0] PIPE_W   = 11'd50,
    parameter logic [10:0] GAP_HALF = 11'd60,
    parameter logic [10:0] FLOOR_Y  = 11'd480,
    parameter logic [10:0] CEIL_Y   = 11'd10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] BirdPosY,
    input  logic [9:0] PipePosX,
    input  logic [9:0] PipePosY,
    output logic       Lost,
    output logic [3:0] ScoreTens,
    output logic [3:0] ScoreOnes,
    output logic [3:0] HiTens,
    output logic [3:0] HiOnes
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_LOST = 2'd2;

    logic [1:0]  state_r;
    logic        lost_r;
    logic        passed_r;
    logic [7:0]  score_r;
    logic [7:0]  hi_r;

    logic [10:0] bird_top_s;
    logic [10:0] bird_bot_s;
    logic [10:0] pipe_left_s;
    logic [10:0] pipe_right_s;
    logic [10:0] gap_ctr_s;
    logic [10:0] gap_top_s;
    logic [10:0] gap_bot_s;
    logic        overlap_x_s;
    logic        pipe_hit_s;
    logic        hit_s;
    logic        past_s;

    // Two-digit BCD increment that holds at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'h99) begin
            res = val;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Geometry in 11 bits so sums never wrap; gap top saturates at zero.
    always_comb begin
        bird_top_s   = {1'b0, BirdPosY};
        bird_bot_s   = bird_top_s + BIRD_SZ;
        pipe_left_s  = {1'b0, PipePosX};
        pipe_right_s = pipe_left_s + PIPE_W;
        gap_ctr_s    = {1'b0, PipePosY};
        if (gap_ctr_s >= GAP_HALF) begin
            gap_top_s = gap_ctr_s - GAP_HALF;
        end else begin
            gap_top_s = 11'd0;
        end
        gap_bot_s    = gap_ctr_s + GAP_HALF;
        overlap_x_s  = (pipe_left_s <= (BIRD_X + BIRD_SZ)) && (pipe_right_s >= BIRD_X);
        pipe_hit_s   = overlap_x_s && ((bird_top_s < gap_top_s) || (bird_bot_s > gap_bot_s));
        hit_s        = pipe_hit_s || (bird_bot_s >= FLOOR_Y) || (bird_top_s < CEIL_Y);
        past_s       = (pipe_right_s < BIRD_X);
    end

    // Round state machine, scoring on the rising edge of past, high-score capture on loss.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            lost_r   <= 1'b0;
            passed_r <= 1'b0;
            score_r  <= 8'h00;
            hi_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r  <= ST_PLAY;
                        score_r  <= 8'h00;
                        passed_r <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    passed_r <= past_s;
                    if (hit_s) begin
                        state_r <= ST_LOST;
                        lost_r  <= 1'b1;
                        if (score_r > hi_r) begin
                            hi_r <= score_r;
                        end
                    end else if (past_s && !passed_r) begin
                        score_r <= bcd_inc(score_r);
                    end
                end
                ST_LOST: begin
                    if (Start) begin
                        state_r <= ST_IDLE;
                        lost_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    lost_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Lost      = lost_r;
    assign ScoreTens = score_r[7:4];
    assign ScoreOnes = score_r[3:0];
    assign HiTens    = hi_r[7:4];
    assign HiOnes    = hi_r[3:0];

endmodule
